// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt entry and ERET sequencer.
package exc_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TAKE,
    ST_VECTOR,
    ST_RET
  } state_e;

  // Winning source after priority and readiness are applied
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_INT,
    SRC_EXC,
    SRC_WAIT,
    SRC_ERET
  } src_e;

  localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

  // Captured payload: code/bd for CAUSE, addr is the EPC value or the ERET target
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              bd;
    logic [XLEN-1:0]   addr;
  } exc_info_t;

endpackage

// File: rtl/exc_prio.sv
// Combinational arbitration of interrupt / exception / ERET and EPC selection.
module exc_prio
  import exc_ctrl_pkg::*;
#(
  parameter logic [CODE_W-1:0] INT_CODE = EXC_INT
) (
  input  logic              intreq,
  input  logic              pipe_valid_m,
  input  logic [XLEN-1:0]   pc_m,
  input  logic              bd_m,
  input  logic              exc_valid_m,
  input  logic [CODE_W-1:0] exc_code_m,
  input  logic              eret_m,
  input  logic              mem_busy,
  input  logic [XLEN-1:0]   epc_in,
  output src_e              src,
  output exc_info_t         info
);

  logic            ready;
  logic [XLEN-1:0] epc_sel;

  assign ready = pipe_valid_m & ~mem_busy;
  // Delay-slot instructions restart at the branch; wraps modulo 2^32
  assign epc_sel = bd_m ? (pc_m - XLEN'(4)) : pc_m;

  always_comb begin
    src  = SRC_NONE;
    info = '{code: '0, bd: 1'b0, addr: '0};
    if (intreq) begin
      if (ready) begin
        src  = SRC_INT;
        info = '{code: INT_CODE, bd: bd_m, addr: epc_sel};
      end else begin
        src = SRC_WAIT;
      end
    end else if (exc_valid_m && ready) begin
      src  = SRC_EXC;
      info = '{code: exc_code_m, bd: bd_m, addr: epc_sel};
    end else if (exc_valid_m && mem_busy) begin
      src = SRC_WAIT;
    end else if (eret_m && !mem_busy) begin
      src  = SRC_ERET;
      info = '{code: '0, bd: 1'b0, addr: epc_in};
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt entry and ERET return sequencer; all outputs are registered.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0]   HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter logic [CODE_W-1:0] INT_CODE     = EXC_INT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intreq,
  input  logic              pipe_valid_m,
  input  logic [XLEN-1:0]   pc_m,
  input  logic              bd_m,
  input  logic              exc_valid_m,
  input  logic [CODE_W-1:0] exc_code_m,
  input  logic              eret_m,
  input  logic              mem_busy,
  input  logic [XLEN-1:0]   epc_in,
  output logic              exl_set,
  output logic              exl_clr,
  output logic              cause_we,
  output logic [CODE_W-1:0] exc_code,
  output logic              bd_out,
  output logic [XLEN-1:0]   epc_out,
  output logic              flush,
  output logic              stall,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   redirect_pc
);

  state_e    state_q, state_d;
  exc_info_t cap_q, cap_d;
  src_e      src;
  exc_info_t info;

  logic              exl_set_d, exl_clr_d, cause_we_d, bd_out_d;
  logic              flush_d, stall_d, pc_redirect_d;
  logic [CODE_W-1:0] exc_code_d;
  logic [XLEN-1:0]   epc_out_d, redirect_pc_d;

  exc_prio #(.INT_CODE(INT_CODE)) u_prio (
    .intreq       (intreq),
    .pipe_valid_m (pipe_valid_m),
    .pc_m         (pc_m),
    .bd_m         (bd_m),
    .exc_valid_m  (exc_valid_m),
    .exc_code_m   (exc_code_m),
    .eret_m       (eret_m),
    .mem_busy     (mem_busy),
    .epc_in       (epc_in),
    .src          (src),
    .info         (info)
  );

  // Next state / capture, then outputs decoded from the next state so they register with it
  always_comb begin
    state_d       = state_q;
    cap_d         = cap_q;
    exl_set_d     = 1'b0;
    exl_clr_d     = 1'b0;
    cause_we_d    = 1'b0;
    exc_code_d    = '0;
    bd_out_d      = 1'b0;
    epc_out_d     = '0;
    flush_d       = 1'b0;
    stall_d       = 1'b0;
    pc_redirect_d = 1'b0;
    redirect_pc_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        unique case (src)
          SRC_INT, SRC_EXC: begin state_d = ST_TAKE; cap_d = info; end
          SRC_WAIT:         state_d = ST_WAIT;
          SRC_ERET:         begin state_d = ST_RET; cap_d = info; end
          default:          state_d = ST_IDLE;
        endcase
      end
      ST_WAIT: begin
        // An ERET arriving here is deferred: fall back to IDLE and re-evaluate
        unique case (src)
          SRC_INT, SRC_EXC: begin state_d = ST_TAKE; cap_d = info; end
          SRC_WAIT:         state_d = ST_WAIT;
          default:          state_d = ST_IDLE;
        endcase
      end
      ST_TAKE:   state_d = ST_VECTOR;
      ST_VECTOR: state_d = ST_IDLE;
      ST_RET:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_WAIT: stall_d = 1'b1;
      ST_TAKE: begin
        exl_set_d  = 1'b1;
        cause_we_d = 1'b1;
        flush_d    = 1'b1;
        stall_d    = 1'b1;
        exc_code_d = cap_d.code;
        bd_out_d   = cap_d.bd;
        epc_out_d  = cap_d.addr;
      end
      ST_VECTOR: begin
        pc_redirect_d = 1'b1;
        redirect_pc_d = HANDLER_ADDR;
      end
      ST_RET: begin
        exl_clr_d     = 1'b1;
        flush_d       = 1'b1;
        pc_redirect_d = 1'b1;
        redirect_pc_d = cap_d.addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cap_q       <= '{code: '0, bd: 1'b0, addr: '0};
      exl_set     <= 1'b0;
      exl_clr     <= 1'b0;
      cause_we    <= 1'b0;
      exc_code    <= '0;
      bd_out      <= 1'b0;
      epc_out     <= '0;
      flush       <= 1'b0;
      stall       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      exl_set     <= exl_set_d;
      exl_clr     <= exl_clr_d;
      cause_we    <= cause_we_d;
      exc_code    <= exc_code_d;
      bd_out      <= bd_out_d;
      epc_out     <= epc_out_d;
      flush       <= flush_d;
      stall       <= stall_d;
      pc_redirect <= pc_redirect_d;
      redirect_pc <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        intreq, pipe_valid_m, bd_m, exc_valid_m, eret_m, mem_busy;
  logic [31:0] pc_m, epc_in;
  logic [4:0]  exc_code_m;
  logic        exl_set, exl_clr, cause_we, bd_out, flush, stall, pc_redirect;
  logic [4:0]  exc_code;
  logic [31:0] epc_out, redirect_pc;

  int passed = 0;
  int total  = 0;

  // Control bit order: exl_set exl_clr cause_we flush stall pc_redirect
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_WAIT = 6'b000010;
  localparam logic [5:0] C_TAKE = 6'b101110;
  localparam logic [5:0] C_VEC  = 6'b000001;
  localparam logic [5:0] C_RET  = 6'b010101;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .intreq(intreq), .pipe_valid_m(pipe_valid_m),
    .pc_m(pc_m), .bd_m(bd_m), .exc_valid_m(exc_valid_m), .exc_code_m(exc_code_m),
    .eret_m(eret_m), .mem_busy(mem_busy), .epc_in(epc_in),
    .exl_set(exl_set), .exl_clr(exl_clr), .cause_we(cause_we), .exc_code(exc_code),
    .bd_out(bd_out), .epc_out(epc_out), .flush(flush), .stall(stall),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ctl();
    return {exl_set, exl_clr, cause_we, flush, stall, pc_redirect};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    intreq = 0; pipe_valid_m = 0; bd_m = 0; exc_valid_m = 0; eret_m = 0;
    mem_busy = 0; pc_m = '0; epc_in = '0; exc_code_m = '0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    tick();
    total++; if (ctl() !== C_IDLE) $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_IDLE); else passed++;
    total++; if ({epc_out, redirect_pc, exc_code, bd_out} !== 70'd0)
      $display("FAIL reset_data got epc=%h rpc=%h code=%0d bd=%b exp all 0", epc_out, redirect_pc, exc_code, bd_out);
    else passed++;
    reset = 0;
    tick();
  endtask

  task automatic test_int_ready();
    intreq = 1; pipe_valid_m = 1; pc_m = 32'h3010; bd_m = 0;
    tick();
    clear_inputs();
    total++; if (ctl() !== C_TAKE) $display("FAIL int_take_ctl got=%b exp=%b", ctl(), C_TAKE); else passed++;
    total++; if ({exc_code, bd_out, epc_out} !== {5'd0, 1'b0, 32'h3010})
      $display("FAIL int_take_data got code=%0d bd=%b epc=%h exp code=0 bd=0 epc=3010", exc_code, bd_out, epc_out);
    else passed++;
    tick();
    total++; if ({ctl(), redirect_pc} !== {C_VEC, 32'h4180})
      $display("FAIL int_vector got ctl=%b rpc=%h exp ctl=%b rpc=4180", ctl(), redirect_pc, C_VEC);
    else passed++;
    tick();
    total++; if (ctl() !== C_IDLE) $display("FAIL int_back_idle got=%b exp=%b", ctl(), C_IDLE); else passed++;
  endtask

  task automatic test_delay_slot();
    exc_valid_m = 1; exc_code_m = 5'd12; pipe_valid_m = 1; pc_m = 32'h3020; bd_m = 1;
    tick();
    clear_inputs();
    total++; if ({ctl(), exc_code, bd_out, epc_out} !== {C_TAKE, 5'd12, 1'b1, 32'h301C})
      $display("FAIL bd_take got ctl=%b code=%0d bd=%b epc=%h exp ctl=%b code=12 bd=1 epc=301c",
               ctl(), exc_code, bd_out, epc_out, C_TAKE);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_wrap();
    exc_valid_m = 1; exc_code_m = 5'd10; pipe_valid_m = 1; pc_m = 32'h0000_0003; bd_m = 1;
    tick();
    clear_inputs();
    total++; if ({exc_code, bd_out, epc_out} !== {5'd10, 1'b1, 32'hFFFF_FFFF})
      $display("FAIL epc_wrap got code=%0d bd=%b epc=%h exp code=10 bd=1 epc=ffffffff", exc_code, bd_out, epc_out);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_mem_busy();
    intreq = 1; pipe_valid_m = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      pc_m = 32'h3100 + 32'(i * 4);
      tick();
      total++; if (ctl() !== C_WAIT) $display("FAIL busy_stall%0d got=%b exp=%b", i, ctl(), C_WAIT); else passed++;
    end
    mem_busy = 0; pc_m = 32'h3200;
    tick();
    clear_inputs();
    total++; if ({ctl(), epc_out} !== {C_TAKE, 32'h3200})
      $display("FAIL busy_take got ctl=%b epc=%h exp ctl=%b epc=3200", ctl(), epc_out, C_TAKE);
    else passed++;
    tick();
    total++; if (ctl() !== C_VEC) $display("FAIL busy_vector got=%b exp=%b", ctl(), C_VEC); else passed++;
    tick();
  endtask

  task automatic test_priority();
    intreq = 1; exc_valid_m = 1; exc_code_m = 5'd4; eret_m = 1;
    pipe_valid_m = 1; pc_m = 32'h3300; epc_in = 32'h3500;
    tick();
    clear_inputs();
    total++; if ({ctl(), exc_code, epc_out} !== {C_TAKE, 5'd0, 32'h3300})
      $display("FAIL prio_take got ctl=%b code=%0d epc=%h exp ctl=%b code=0 epc=3300", ctl(), exc_code, epc_out, C_TAKE);
    else passed++;
    tick();
    total++; if (ctl() !== C_VEC) $display("FAIL prio_vector got=%b exp=%b", ctl(), C_VEC); else passed++;
    tick();
    total++; if (ctl() !== C_IDLE) $display("FAIL prio_single_take got=%b exp=%b", ctl(), C_IDLE); else passed++;
  endtask

  task automatic test_eret();
    eret_m = 1; pipe_valid_m = 1; epc_in = 32'h3040;
    tick();
    clear_inputs();
    total++; if ({ctl(), redirect_pc} !== {C_RET, 32'h3040})
      $display("FAIL eret_ret got ctl=%b rpc=%h exp ctl=%b rpc=3040", ctl(), redirect_pc, C_RET);
    else passed++;
    tick();
    total++; if (ctl() !== C_IDLE) $display("FAIL eret_idle got=%b exp=%b", ctl(), C_IDLE); else passed++;
  endtask

  task automatic test_eret_busy();
    eret_m = 1; pipe_valid_m = 1; mem_busy = 1; epc_in = 32'h3060;
    tick();
    total++; if (ctl() !== C_IDLE) $display("FAIL eret_busy_hold got=%b exp=%b", ctl(), C_IDLE); else passed++;
    mem_busy = 0; epc_in = 32'h3064;
    tick();
    clear_inputs();
    total++; if ({ctl(), redirect_pc} !== {C_RET, 32'h3064})
      $display("FAIL eret_busy_ret got ctl=%b rpc=%h exp ctl=%b rpc=3064", ctl(), redirect_pc, C_RET);
    else passed++;
    tick();
  endtask

  task automatic test_wait_drop();
    intreq = 1; pipe_valid_m = 1; mem_busy = 1;
    tick();
    total++; if (ctl() !== C_WAIT) $display("FAIL drop_wait got=%b exp=%b", ctl(), C_WAIT); else passed++;
    intreq = 0; mem_busy = 0; eret_m = 1; epc_in = 32'h3080;
    tick();
    total++; if (ctl() !== C_IDLE) $display("FAIL drop_eret_deferred got=%b exp=%b", ctl(), C_IDLE); else passed++;
    tick();
    clear_inputs();
    total++; if ({ctl(), redirect_pc} !== {C_RET, 32'h3080})
      $display("FAIL drop_eret_taken got ctl=%b rpc=%h exp ctl=%b rpc=3080", ctl(), redirect_pc, C_RET);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_take();
    intreq = 1; pipe_valid_m = 1; pc_m = 32'h3400;
    tick();
    clear_inputs();
    total++; if (ctl() !== C_TAKE) $display("FAIL rst_pre_take got=%b exp=%b", ctl(), C_TAKE); else passed++;
    #1 reset = 1;
    #1;
    total++; if ({ctl(), epc_out, exc_code} !== {C_IDLE, 32'd0, 5'd0})
      $display("FAIL rst_async got ctl=%b epc=%h code=%0d exp all 0", ctl(), epc_out, exc_code);
    else passed++;
    tick();
    reset = 0;
    tick();
    total++; if ({ctl(), redirect_pc} !== {C_IDLE, 32'd0})
      $display("FAIL rst_no_vector got ctl=%b rpc=%h exp ctl=%b rpc=0", ctl(), redirect_pc, C_IDLE);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_int_ready();
    test_delay_slot();
    test_wrap();
    test_mem_busy();
    test_priority();
    test_eret();
    test_eret_busy();
    test_wait_drop();
    test_reset_mid_take();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Sequences exception and interrupt entry and ERET return for the pipelined CPU.
- Sits between the M-stage pipeline register, the CP0 register file and the PC/NPC logic.
- Arbitrates three sources: the CP0 interrupt request, the M-stage synchronous exception, and the M-stage ERET.
- Generates EXL set/clear, ExcCode, the EPC write value, the pipeline flush/stall, and the PC redirect.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt handler entry address.
- INT_CODE, 5'd0, ExcCode written for external interrupts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- intreq  in  1  interrupt request from CP0 (already masked by IM/IE/EXL).
- pipe_valid_m  in  1  M stage holds a real instruction, not a bubble.
- pc_m  in  32  PC of the M-stage instruction.
- bd_m  in  1  M-stage instruction is in a branch delay slot.
- exc_valid_m  in  1  M-stage instruction raised a synchronous exception.
- exc_code_m  in  5  ExcCode of that exception.
- eret_m  in  1  M-stage instruction is ERET.
- mem_busy  in  1  a multi-cycle data-memory access is outstanding.
- epc_in  in  32  current EPC from CP0 (bypassed value).
- exl_set  out  1  set SR.EXL at the next edge.
- exl_clr  out  1  clear SR.EXL at the next edge.
- cause_we  out  1  write exc_code/bd into CAUSE and epc_out into EPC.
- exc_code  out  5  ExcCode for CAUSE[6:2].
- bd_out  out  1  BD bit for CAUSE[31].
- epc_out  out  32  EPC write value.
- flush  out  1  clear the F/D/E/M pipeline registers.
- stall  out  1  freeze the F/D stages.
- pc_redirect  out  1  NPC takes redirect_pc this cycle.
- redirect_pc  out  32  redirect target.

Behaviour:
- States: IDLE, WAIT, TAKE, VECTOR, RET. All outputs are Moore-style from state plus capture registers; there is no combinational path from inputs to outputs.
- Reset (asynchronous, any state): state=IDLE; capture registers=0; every output=0.
- Events are evaluated in IDLE only. Priority: intreq > exc_valid_m > eret_m.
- "ready" = pipe_valid_m & ~mem_busy.
- IDLE transitions:
  - intreq & ready: capture code=INT_CODE, bd=bd_m, epc=(bd_m ? pc_m-4 : pc_m); go to TAKE.
  - intreq & ~ready: go to WAIT.
  - else exc_valid_m & ready: capture exc_code_m with the same EPC rule; go to TAKE.
  - else exc_valid_m & mem_busy: go to WAIT.
  - else eret_m & ~mem_busy: capture target=epc_in; go to RET.
  - else eret_m & mem_busy: stay in IDLE; ERET is re-evaluated next cycle.
- WAIT: stall=1.
  - Each cycle, re-evaluate with IDLE priority, using the ready inputs.
  - If both intreq and exc_valid_m have dropped, return to IDLE with no side effects.
  - An ERET seen in WAIT is not taken; the block returns to IDLE first.
- TAKE (exactly 1 cycle): exl_set=1, cause_we=1, flush=1, stall=1; exc_code/bd_out/epc_out come from the capture registers. Next state is VECTOR.
- VECTOR (exactly 1 cycle): pc_redirect=1, redirect_pc=HANDLER_ADDR, stall=0, flush=0. Next state is IDLE.
  - SR.EXL is already set here, so CP0 deasserts intreq; no re-entry is possible.
- RET (exactly 1 cycle): exl_clr=1, flush=1, pc_redirect=1, redirect_pc=captured epc_in. Next state is IDLE.
- exl_set and exl_clr are never asserted in the same cycle.
- Entry latency: an event in IDLE with ready gives TAKE at cycle +1 and VECTOR at cycle +2.
- ERET latency: RET at cycle +1.
- EPC arithmetic: 32-bit unsigned subtraction, wrap-around allowed (pc_m=0 with bd gives 32'hFFFF_FFFC). The low 2 bits are passed through unmodified.
- Simultaneous events:
  - intreq with eret_m: the interrupt wins and EPC is the ERET's PC, so ERET re-executes after the handler.
  - intreq with exc_valid_m: the interrupt wins and the exception re-raises on return.
- Reset in TAKE/VECTOR/RET aborts the sequence with no partial output in the following cycle.

Decomposition:
- Shared package: state encoding constants (IDLE/WAIT/TAKE/VECTOR/RET); ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12); the default HANDLER_ADDR.
- Sub-module exc_prio: combinational priority and EPC selection (winning source, code, bd, epc). The FSM and capture registers stay in exc_ctrl.

Test Plan:
- Interrupt, ready: intreq=1, pipe_valid_m=1, pc_m=32'h3010, bd_m=0 -> next cycle TAKE with exl_set=1, cause_we=1, exc_code=0, epc_out=32'h3010, flush=1 -> following cycle pc_redirect=1, redirect_pc=32'h4180.
- Delay slot: exc_valid_m=1, exc_code_m=12, pc_m=32'h3020, bd_m=1 -> epc_out=32'h301C, bd_out=1, exc_code=12.
- Memory busy: intreq=1, mem_busy=1 for 3 cycles, then 0 -> stall=1 for 3 cycles, TAKE on the 4th, epc_out = pc_m sampled on the ready cycle.
- Priority: intreq=1, exc_valid_m=1 (code 4), eret_m=1 on the same cycle -> exc_code=0, exactly one TAKE, no exl_clr.
- ERET: eret_m=1, epc_in=32'h3040 -> next cycle exl_clr=1, flush=1, pc_redirect=1, redirect_pc=32'h3040; exl_set=0 throughout.
- Reset mid-TAKE: assert reset asynchronously during TAKE -> all outputs 0 immediately, no VECTOR cycle, IDLE after release.
